// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths and request type for the SRAM port-0 front-end
package sram_pkg;

  localparam int SRAM_ADDR_WIDTH = 11;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_NUM_WMASKS = 4;

  typedef struct packed {
    logic                       we;
    logic [SRAM_NUM_WMASKS-1:0] wmask;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - read-response FIFO with wrap-bit pointers and occupancy count
//
// Purpose: holds read data returned by the macro until the consumer accepts it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push/i_push_data write side
//   i_pop             read side (ignored when empty)
//   o_head            head entry, zero while empty
//   o_valid           FIFO not empty
//   o_count           current occupancy (0..DEPTH)
module sram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_wptr == r_rptr);
  // Same index, opposite lap: the writer is one full pass ahead of the reader.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
  end

  assign o_valid = !w_empty;
  assign o_head  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// rtl/sram_rw_port_ctrl.sv - valid/ready front-end for port 0 (RW) of the 32x2048 1rw1r SRAM macro
//
// Purpose: registers accepted requests onto the macro's port-0 inputs, captures
// dout0 two edges after a read is accepted and returns it through a response FIFO.
// Ports:
//   clk0, rst0_n                  clock shared with the macro, async active-low reset
//   req_*                         request channel (valid/ready)
//   rsp_*                         read-response channel (valid/ready), in request order
//   sram_csb0/web0/wmask0/addr0/din0  registered macro inputs
//   sram_dout0                    macro read data
module sram_rw_port_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  // Two extra bits of headroom: FIFO count (0..RSP_DEPTH) plus two in-flight flags.
  localparam int CW = $clog2(RSP_DEPTH) + 2;

  logic                  r_csb;
  logic                  r_web;
  logic [NUM_WMASKS-1:0] r_wmask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_s0;
  logic                  r_s1;

  logic                  w_accept;
  logic                  w_ready;
  logic                  w_pop;
  logic [CW-2:0]         w_fifo_count;
  logic [CW-1:0]         w_outstanding;

  // Every read that may still land in the FIFO holds a credit, so a push can
  // never find the FIFO full without a matching pop.
  assign w_outstanding = {1'b0, w_fifo_count} + CW'(r_s0) + CW'(r_s1);
  assign w_ready       = (w_outstanding < CW'(RSP_DEPTH));
  assign w_accept      = req_valid && w_ready;
  assign w_pop         = rsp_valid && rsp_ready;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else if (w_accept) begin
      r_csb   <= 1'b0;
      r_web   <= ~req_we;
      r_wmask <= req_we ? req_wmask : '0;
      r_addr  <= req_addr;
      r_din   <= req_wdata;
    end else begin
      // Deselect only; address/data/mask keep their last values to avoid toggling.
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
    end
  end

  // s0: read registered onto the macro pins; s1: macro sampled it, dout0
  // becomes valid at the following negedge and is captured on the next posedge.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= w_accept && !req_we;
      r_s1 <= r_s0;
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk         (clk0),
    .rst_n       (rst0_n),
    .i_push      (r_s1),
    .i_push_data (sram_dout0),
    .i_pop       (w_pop),
    .o_head      (rsp_rdata),
    .o_valid     (rsp_valid),
    .o_count     (w_fifo_count)
  );

  assign req_ready   = w_ready;
  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// tb/tb_sram_rw_port_ctrl.sv - scoreboard bench for sram_rw_port_ctrl with a behavioural macro model
module tb_sram_rw_port_ctrl;
  import sram_pkg::*;

  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int DW = SRAM_DATA_WIDTH;
  localparam int NM = SRAM_NUM_WMASKS;

  logic          clk0 = 1'b0;
  logic          rst0_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [NM-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb0;
  logic          sram_web0;
  logic [NM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0 = '0;

  sram_rw_port_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WMASKS (NM),
    .RSP_DEPTH  (4)
  ) dut (
    .clk0        (clk0),
    .rst0_n      (rst0_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_wmask   (req_wmask),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always #5 clk0 = ~clk0;

  // Macro model: samples pins at posedge, performs the access at negedge.
  logic [DW-1:0] mem [2048];
  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [NM-1:0] m_wmask;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  always @(posedge clk0) begin
    m_csb   <= sram_csb0;
    m_web   <= sram_web0;
    m_wmask <= sram_wmask0;
    m_addr  <= sram_addr0;
    m_din   <= sram_din0;
  end

  always @(negedge clk0) begin
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < NM; b++)
          if (m_wmask[b]) mem[m_addr][b*8 +: 8] <= m_din[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[m_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk0) cyc++;

  int n_tests = 0;
  int n_fail  = 0;
  int n_spurious = 0;
  int n_accepts = 0;
  int n_stalls  = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;
  exp_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is handed over.
  always @(negedge clk0) begin
    if (rst0_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_spurious++;
        $display("FAIL spurious_rsp: got data 0x%0h expected no response", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.data);
        if (e.chk_lat) check("rsp_latency", cyc - e.acc_cyc, 2);
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input bit we, input logic [NM-1:0] wm, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit expect_rsp, input bit chk_lat);
    int budget;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_wmask = wm;
    req_addr  = a;
    req_wdata = wd;
    budget    = 0;
    @(negedge clk0);
    while (!req_ready && budget < 60) begin
      n_stalls++;
      budget++;
      @(posedge clk0); #1;
      @(negedge clk0);
    end
    if (!req_ready) begin
      check("req_accept_timeout", 0, 1);
    end else begin
      n_accepts++;
      if (!we && expect_rsp) begin
        e.data    = mem[a];
        e.acc_cyc = cyc + 1;
        e.chk_lat = chk_lat;
        exp_q.push_back(e);
      end
    end
    @(posedge clk0); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk0); #1;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 60) begin
      budget++;
      @(posedge clk0); #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  logic [DW-1:0] snap [2048];
  bit            same;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    repeat (3) @(posedge clk0);
    #1;
    // Reset state
    check("rst_csb0",   sram_csb0, 1);
    check("rst_web0",   sram_web0, 1);
    check("rst_wmask0", sram_wmask0, 0);
    check("rst_addr0",  sram_addr0, 0);
    check("rst_din0",   sram_din0, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst0_n = 1'b1;
    idle(2);
    check("rst_req_ready", req_ready, 1);

    // Full write then read with exact latency
    issue(1'b1, 4'hF, 11'h005, 32'hDEADBEEF, 1'b0, 1'b0);
    check("wr_csb0",  sram_csb0, 0);
    check("wr_web0",  sram_web0, 0);
    check("wr_wmask", sram_wmask0, 4'hF);
    check("wr_addr",  sram_addr0, 11'h005);
    check("wr_din",   sram_din0, 32'hDEADBEEF);
    mem[11'h005] = mem[11'h005]; // scoreboard value comes from macro model below
    begin
      exp_t e;
      issue(1'b0, 4'h0, 11'h005, 32'h0, 1'b0, 1'b0);
      check("rd_wmask_zero", sram_wmask0, 0);
      check("rd_web0", sram_web0, 1);
      e.data = 32'hDEADBEEF; e.acc_cyc = cyc; e.chk_lat = 1'b1;
      exp_q.push_back(e);
    end
    drain("drain_t1");

    // Byte-masked write
    issue(1'b1, 4'hF, 11'h7FF, 32'h11223344, 1'b0, 1'b0);
    issue(1'b1, 4'b0101, 11'h7FF, 32'hAABBCCDD, 1'b0, 1'b0);
    begin
      exp_t e;
      issue(1'b0, 4'h0, 11'h7FF, 32'h0, 1'b0, 1'b0);
      e.data = 32'h11BB33DD; e.acc_cyc = cyc; e.chk_lat = 1'b1;
      exp_q.push_back(e);
    end
    drain("drain_t2");

    // Back-to-back reads, no stalls expected
    for (int i = 0; i < 8; i++) mem[i] = DW'(i);
    n_stalls = 0;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      issue(1'b0, 4'h0, AW'(i), 32'h0, 1'b0, 1'b0);
      e.data = DW'(i); e.acc_cyc = cyc; e.chk_lat = 1'b1;
      exp_q.push_back(e);
    end
    check("b2b_no_stall", n_stalls, 0);
    drain("drain_t3");

    // Back-pressure: 4 credits, then stall until rsp_ready returns
    for (int i = 0; i < 6; i++) mem[32 + i] = 32'hC0DE0000 + DW'(i);
    rsp_ready = 1'b0;
    n_accepts = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          exp_t e;
          issue(1'b0, 4'h0, AW'(32 + i), 32'h0, 1'b0, 1'b0);
          e.data = 32'hC0DE0000 + DW'(i); e.acc_cyc = cyc; e.chk_lat = 1'b0;
          exp_q.push_back(e);
        end
      end
      begin
        repeat (10) @(negedge clk0);
        check("bp_accepts", n_accepts, 4);
        check("bp_req_ready", req_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        @(posedge clk0); #1;
        rsp_ready = 1'b1;
      end
    join
    drain("drain_t4");
    check("bp_total_accepts", n_accepts, 6);

    // Reset with a read in flight
    issue(1'b0, 4'h0, 11'h010, 32'h0, 1'b0, 1'b0);
    #1;
    rst0_n = 1'b0;
    #1;
    check("rst_async_csb0", sram_csb0, 1);
    @(negedge clk0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    idle(2);
    rst0_n = 1'b1;
    idle(8);
    check("rst_no_rsp", n_spurious, 0);

    // Idle cycles leave the macro untouched
    for (int i = 0; i < 2048; i++) snap[i] = mem[i];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk0);
      check("idle_csb0", sram_csb0, 1);
      check("idle_web0", sram_web0, 1);
    end
    same = 1'b1;
    for (int i = 0; i < 2048; i++) if (mem[i] !== snap[i]) same = 1'b0;
    check("idle_mem_unchanged", same, 1);
    check("final_no_spurious", n_spurious, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
